// File: rtl/rom_load_ctrl.sv
// rom_load_ctrl: ROM download controller for a game core.
// Accepts the index-0 download stream into a ROM write port, checks the
// session length against ROM_MIN/ROM_SIZE, holds the game in reset until a
// good image is loaded plus a settle period, and captures DIP and mod bytes
// from their own download indices.
// Ports:
//   clk_sys, reset                 clock, async active-high reset
//   ioctl_download/index/wr/addr/dout  host download bus
//   user_reset                     menu/button reset request (level)
//   dl_addr, dl_data, dl_we        registered ROM write port (1-cycle latency)
//   game_reset, rom_loaded         core reset and load status
//   err_short, err_overflow        sticky status of the last ROM session
//   sw0..sw2, mod_byte             DIP bytes 0..2 and game variant byte
module rom_load_ctrl #(
  parameter logic [16:0] ROM_SIZE      = 17'h1C000,
  parameter logic [16:0] ROM_MIN       = 17'h1C000,
  parameter int unsigned SETTLE_CYCLES = 1024
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        user_reset,
  output logic [16:0] dl_addr,
  output logic [7:0]  dl_data,
  output logic        dl_we,
  output logic        game_reset,
  output logic        rom_loaded,
  output logic        err_short,
  output logic        err_overflow,
  output logic [7:0]  sw0,
  output logic [7:0]  sw1,
  output logic [7:0]  sw2,
  output logic [7:0]  mod_byte
);

  localparam int unsigned SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SCW-1:0] SETTLE_LOAD  = SCW'(SETTLE_CYCLES - 1);
  localparam logic [24:0]    ROM_SIZE_EXT = 25'(ROM_SIZE);
  localparam logic [16:0]    BYTE_CNT_MAX = 17'h1FFFF;
  localparam logic [7:0]     IDX_ROM      = 8'd0;
  localparam logic [7:0]     IDX_MOD      = 8'd1;
  localparam logic [7:0]     IDX_DIP      = 8'd254;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [16:0]     r_byte_cnt;
  logic [SCW-1:0]  r_settle_cnt;

  logic w_rom_session;
  logic w_load_entry;
  logic w_load_ok;
  logic w_load_short;
  logic w_settle_load;
  logic w_rom_wr;
  logic w_addr_ok;
  logic w_dip_wr;
  logic w_mod_wr;

  // A ROM session is active while download is high on index 0; any other
  // combination seen in LOAD ends the session.
  assign w_rom_session = ioctl_download && (ioctl_index == IDX_ROM);
  assign w_rom_wr      = (r_state == ST_LOAD) && w_rom_session && ioctl_wr;
  assign w_addr_ok     = (ioctl_addr < ROM_SIZE_EXT);
  assign w_dip_wr      = ioctl_wr && (ioctl_index == IDX_DIP) && (ioctl_addr[24:3] == 22'd0);
  assign w_mod_wr      = ioctl_wr && (ioctl_index == IDX_MOD);

  // State register
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) r_state <= ST_WAIT;
    else       r_state <= w_state_next;
  end

  // Next-state and transition strobes
  always_comb begin
    w_state_next  = r_state;
    w_load_entry  = 1'b0;
    w_load_ok     = 1'b0;
    w_load_short  = 1'b0;
    w_settle_load = 1'b0;
    case (r_state)
      ST_WAIT: begin
        if (w_rom_session) begin
          w_state_next = ST_LOAD;
          w_load_entry = 1'b1;
        end
      end
      ST_LOAD: begin
        if (!w_rom_session) begin
          if (r_byte_cnt >= ROM_MIN) begin
            w_state_next  = ST_SETTLE;
            w_load_ok     = 1'b1;
            w_settle_load = 1'b1;
          end else begin
            w_state_next = ST_WAIT;
            w_load_short = 1'b1;
          end
        end
      end
      ST_SETTLE: begin
        if (user_reset)               w_settle_load = 1'b1;
        else if (r_settle_cnt == '0)  w_state_next  = ST_RUN;
      end
      ST_RUN: begin
        // Session start wins over a simultaneous user reset
        if (w_rom_session) begin
          w_state_next = ST_LOAD;
          w_load_entry = 1'b1;
        end else if (user_reset) begin
          w_state_next  = ST_SETTLE;
          w_settle_load = 1'b1;
        end
      end
      default: w_state_next = ST_WAIT;
    endcase
  end

  // Byte and settle counters
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_byte_cnt   <= '0;
      r_settle_cnt <= '0;
    end else begin
      if (w_load_entry)
        r_byte_cnt <= '0;
      else if (w_rom_wr && w_addr_ok && (r_byte_cnt != BYTE_CNT_MAX))
        r_byte_cnt <= r_byte_cnt + 17'd1;

      if (w_settle_load)
        r_settle_cnt <= SETTLE_LOAD;
      else if ((r_state == ST_SETTLE) && (r_settle_cnt != '0))
        r_settle_cnt <= r_settle_cnt - SCW'(1);
    end
  end

  // ROM write port, one cycle behind the accepted strobe
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dl_we   <= 1'b0;
      dl_addr <= '0;
      dl_data <= '0;
    end else begin
      dl_we <= w_rom_wr && w_addr_ok;
      if (w_rom_wr && w_addr_ok) begin
        dl_addr <= ioctl_addr[16:0];
        dl_data <= ioctl_dout;
      end
    end
  end

  // Status outputs; game_reset tracks the state being entered
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      game_reset   <= 1'b1;
      rom_loaded   <= 1'b0;
      err_short    <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      game_reset <= (w_state_next != ST_RUN);
      if (w_load_entry) begin
        rom_loaded   <= 1'b0;
        err_short    <= 1'b0;
        err_overflow <= 1'b0;
      end else begin
        if (w_load_ok)    rom_loaded <= 1'b1;
        if (w_load_short) begin
          rom_loaded <= 1'b0;
          err_short  <= 1'b1;
        end
        if (w_rom_wr && !w_addr_ok) err_overflow <= 1'b1;
      end
    end
  end

  // DIP bank and mod byte; bank bytes 3..7 have no consumer and are not kept
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sw0      <= '0;
      sw1      <= '0;
      sw2      <= '0;
      mod_byte <= '0;
    end else begin
      if (w_dip_wr) begin
        case (ioctl_addr[2:0])
          3'd0:    sw0 <= ioctl_dout;
          3'd1:    sw1 <= ioctl_dout;
          3'd2:    sw2 <= ioctl_dout;
          default: ;
        endcase
      end
      if (w_mod_wr) mod_byte <= ioctl_dout;
    end
  end

endmodule
